// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline control logic: writeback select
// encodings, the canonical NOP and the hazard controller state encoding.
package pipe_pkg;

   localparam logic [1:0]  LOAD_SEL = 2'b01;
   localparam logic [31:0] NOP_INSN = 32'h00000013;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when enabled and holds at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// flushes, data-memory freeze with timeout, plus stall/flush counters.
module hazard_ctrl #(
   parameter logic [1:0] LOAD_SEL    = pipe_pkg::LOAD_SEL,
   parameter int         MEM_TIMEOUT = 64,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_read_reg1,
   input  logic [4:0]       IF_ID_read_reg2,
   input  logic             IF_ID_use_rs1,
   input  logic             IF_ID_use_rs2,
   input  logic [4:0]       ID_EXE_written_reg,
   input  logic [1:0]       ID_EXE_DatatoReg,
   input  logic             ID_EXE_RegWrite,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_CE,
   output logic             IF_ID_CE,
   output logic             IF_ID_flush,
   output logic             ID_EXE_CE,
   output logic             ID_EXE_bubble,
   output logic             EXE_MEM_CE,
   output logic             MEM_WB_CE,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_pkg::*;

   localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

   hazard_state_e  state_q, state_d;
   logic [WCW-1:0] waitCnt_q, waitCnt_d;
   logic           memErr_q, memErr_d;

   logic loadUse;
   logic memStall;
   logic freeze;
   logic flushEvent;

   assign loadUse = ID_EXE_RegWrite
                 && (ID_EXE_DatatoReg == LOAD_SEL)
                 && (ID_EXE_written_reg != 5'd0)
                 && ((IF_ID_use_rs1 && (IF_ID_read_reg1 == ID_EXE_written_reg))
                  || (IF_ID_use_rs2 && (IF_ID_read_reg2 == ID_EXE_written_reg)));

   assign memStall = dmem_req && !dmem_ready;
   assign freeze   = (state_q == MEM_WAIT) || memStall;

   // Freeze outranks branch and load-use: those inputs stay presented and are
   // acted on once memory lets the pipeline move again.
   always_comb begin
      PC_CE         = 1'b1;
      IF_ID_CE      = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EXE_CE     = 1'b1;
      ID_EXE_bubble = 1'b0;
      EXE_MEM_CE    = 1'b1;
      MEM_WB_CE     = 1'b1;
      flushEvent    = 1'b0;
      if (!rst_n) begin
         flushEvent = 1'b0;
      end else if (freeze) begin
         PC_CE      = 1'b0;
         IF_ID_CE   = 1'b0;
         ID_EXE_CE  = 1'b0;
         EXE_MEM_CE = 1'b0;
         MEM_WB_CE  = 1'b0;
      end else if (branch_taken) begin
         IF_ID_flush   = 1'b1;
         ID_EXE_bubble = 1'b1;
         flushEvent    = 1'b1;
      end else if (loadUse) begin
         PC_CE         = 1'b0;
         IF_ID_CE      = 1'b0;
         ID_EXE_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      memErr_d  = 1'b0;
      case (state_q)
         RUN: begin
            if (memStall) begin
               state_d   = MEM_WAIT;
               waitCnt_d = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d   = RUN;
               waitCnt_d = '0;
            end else if (waitCnt_q == WCW'(MEM_TIMEOUT - 1)) begin
               memErr_d  = 1'b1;
               state_d   = RUN;
               waitCnt_d = '0;
            end else begin
               waitCnt_d = waitCnt_q + WCW'(1);
            end
         end
         default: begin
            state_d   = RUN;
            waitCnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         waitCnt_q <= '0;
         memErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         memErr_q  <= memErr_d;
      end
   end

   assign mem_err = memErr_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (!PC_CE),
      .count_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (flushEvent),
      .count_o (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a behavioural model pushes expected
// outputs into a scoreboard that is compared against the DUT each cycle.
module tb_hazard_ctrl;

   localparam int TO = 4;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd;
   logic        useRs1, useRs2, regWrite;
   logic [1:0]  datatoReg;
   logic        branchTaken, dmemReq, dmemReady;

   logic        pcCe, ifIdCe, ifIdFlush, idExeCe, idExeBubble, exeMemCe, memWbCe, memErr;
   logic [15:0] stallCnt, flushCnt;
   logic        sPcCe, sIfIdCe, sIfIdFlush, sIdExeCe, sIdExeBubble, sExeMemCe, sMemWbCe, sMemErr;
   logic [2:0]  sStallCnt, sFlushCnt;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_read_reg1(rs1), .IF_ID_read_reg2(rs2),
      .IF_ID_use_rs1(useRs1), .IF_ID_use_rs2(useRs2),
      .ID_EXE_written_reg(rd), .ID_EXE_DatatoReg(datatoReg), .ID_EXE_RegWrite(regWrite),
      .branch_taken(branchTaken), .dmem_req(dmemReq), .dmem_ready(dmemReady),
      .PC_CE(pcCe), .IF_ID_CE(ifIdCe), .IF_ID_flush(ifIdFlush), .ID_EXE_CE(idExeCe),
      .ID_EXE_bubble(idExeBubble), .EXE_MEM_CE(exeMemCe), .MEM_WB_CE(memWbCe),
      .mem_err(memErr), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
   );

   // Narrow-counter copy so that saturation of both counters is reachable quickly.
   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(3)) dutSmall (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_read_reg1(rs1), .IF_ID_read_reg2(rs2),
      .IF_ID_use_rs1(useRs1), .IF_ID_use_rs2(useRs2),
      .ID_EXE_written_reg(rd), .ID_EXE_DatatoReg(datatoReg), .ID_EXE_RegWrite(regWrite),
      .branch_taken(branchTaken), .dmem_req(dmemReq), .dmem_ready(dmemReady),
      .PC_CE(sPcCe), .IF_ID_CE(sIfIdCe), .IF_ID_flush(sIfIdFlush), .ID_EXE_CE(sIdExeCe),
      .ID_EXE_bubble(sIdExeBubble), .EXE_MEM_CE(sExeMemCe), .MEM_WB_CE(sMemWbCe),
      .mem_err(sMemErr), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ctrl;
      logic        err;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [2:0]  ssc;
      logic [2:0]  sfc;
   } exp_t;

   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   bit quiet  = 1'b0;

   bit          mSt;
   int          mWc;
   logic        mErr;
   logic [15:0] mSc, mFc;
   logic [2:0]  mSsc, mSfc;

   // Ctrl packing: {PC, IF_ID, IF_ID_flush, ID_EXE, ID_EXE_bubble, EXE_MEM, MEM_WB}
   localparam logic [6:0] C_RUN    = 7'b1101011;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_BRANCH = 7'b1111111;
   localparam logic [6:0] C_LDUSE  = 7'b0001111;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mSt = 1'b0; mWc = 0; mErr = 1'b0;
      mSc = '0; mFc = '0; mSsc = '0; mSfc = '0;
   endtask

   task automatic setHazard(input logic [4:0] d, input logic [1:0] sel, input logic w,
                            input logic [4:0] s1, input logic u1,
                            input logic [4:0] s2, input logic u2);
      rd = d; datatoReg = sel; regWrite = w;
      rs1 = s1; useRs1 = u1; rs2 = s2; useRs2 = u2;
   endtask

   // One full cycle: drive, predict, compare at negedge, advance model at posedge.
   task automatic applyStimulus(input logic rst, input logic br, input logic req, input logic rdy);
      logic  lu, fr;
      exp_t  e, o;
      rst_n = rst; branchTaken = br; dmemReq = req; dmemReady = rdy;
      if (!rst) modelReset();
      lu = regWrite && (datatoReg == 2'b01) && (rd != 5'd0)
        && ((useRs1 && rs1 == rd) || (useRs2 && rs2 == rd));
      fr = mSt || (req && !rdy);
      if (!rst)      e.ctrl = C_RUN;
      else if (fr)   e.ctrl = C_FREEZE;
      else if (br)   e.ctrl = C_BRANCH;
      else if (lu)   e.ctrl = C_LDUSE;
      else           e.ctrl = C_RUN;
      e.err = mErr; e.sc = mSc; e.fc = mFc; e.ssc = mSsc; e.sfc = mSfc;
      sb.push_back(e);

      @(negedge clk);
      o = sb.pop_front();
      if (!quiet) begin
         checkOutput("ctrl", {25'd0, pcCe, ifIdCe, ifIdFlush, idExeCe, idExeBubble, exeMemCe, memWbCe}, {25'd0, o.ctrl});
         checkOutput("mem_err", {31'd0, memErr}, {31'd0, o.err});
         checkOutput("stall_cnt", {16'd0, stallCnt}, {16'd0, o.sc});
         checkOutput("flush_cnt", {16'd0, flushCnt}, {16'd0, o.fc});
         checkOutput("small_stall_cnt", {29'd0, sStallCnt}, {29'd0, o.ssc});
         checkOutput("small_flush_cnt", {29'd0, sFlushCnt}, {29'd0, o.sfc});
      end

      @(posedge clk);
      if (rst) begin
         if (!o.ctrl[6]) begin
            if (mSc != 16'hFFFF) mSc = mSc + 16'd1;
            if (mSsc != 3'd7)    mSsc = mSsc + 3'd1;
         end
         if (o.ctrl[4]) begin
            if (mFc != 16'hFFFF) mFc = mFc + 16'd1;
            if (mSfc != 3'd7)    mSfc = mSfc + 3'd1;
         end
         mErr = 1'b0;
         if (!mSt) begin
            if (req && !rdy) begin mSt = 1'b1; mWc = 1; end
         end else if (rdy) begin
            mSt = 1'b0; mWc = 0;
         end else if (mWc == TO - 1) begin
            mErr = 1'b1; mSt = 1'b0; mWc = 0;
         end else begin
            mWc++;
         end
      end
      #1;
   endtask

   initial begin
      modelReset();
      setHazard(5'd5, 2'b01, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      rst_n = 1'b0; branchTaken = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0;
      @(posedge clk); #1;

      // Reset gates every control output regardless of hazard/branch/memory inputs.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Branch together with a load-use: flush wins, no stall.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      setHazard(5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Load-use via rs1, then via rs2; the load then leaves ID_EXE.
      setHazard(5'd5, 2'b01, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      setHazard(5'd0, 2'b00, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      setHazard(5'd9, 2'b01, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Non-stalling look-alikes: rd=x0, non-load select, no RegWrite, unused operand.
      setHazard(5'd0, 2'b01, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      setHazard(5'd5, 2'b00, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      setHazard(5'd5, 2'b01, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      setHazard(5'd5, 2'b01, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Memory wait: three not-ready cycles, ready sampled, branch held throughout.
      setHazard(5'd7, 2'b01, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      setHazard(5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Timeout: ready never arrives; error pulse, then a new wait begins.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

      // Reset deep in a wait, one cycle before the timeout would fire.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      // Saturate the narrow counters with stalls and branch flushes.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      // Saturate the 16-bit stall counter, then confirm it holds.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      quiet = 1'b1;
      for (int i = 0; i < 65540; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      quiet = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Monitors the contents of the ID_EXE register, the ID-stage source registers, branch resolution in EXE, and the data-memory handshake.
- Drives the CE and bubble/flush controls of PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB.
- Keeps saturating stall and flush performance counters.

Parameters:
- LOAD_SEL, 2'b01: ID_EXE_DatatoReg encoding for "load from memory".
- MEM_TIMEOUT, 64: maximum dmem wait cycles before error abort.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_read_reg1  in  5  rs1 of the instruction in ID.
- IF_ID_read_reg2  in  5  rs2 of the instruction in ID.
- IF_ID_use_rs1  in  1  ID instruction reads rs1.
- IF_ID_use_rs2  in  1  ID instruction reads rs2.
- ID_EXE_written_reg  in  5  rd held in the ID_EXE register.
- ID_EXE_DatatoReg  in  2  writeback select held in ID_EXE.
- ID_EXE_RegWrite  in  1  RegWrite held in ID_EXE.
- branch_taken  in  1  EXE resolved a taken branch or jump.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- PC_CE  out  1  PC enable.
- IF_ID_CE  out  1  IF_ID enable.
- IF_ID_flush  out  1  load NOP (32'h00000013) into IF_ID.
- ID_EXE_CE  out  1  ID_EXE enable.
- ID_EXE_bubble  out  1  zero ID_EXE control (RegWrite, mem_w) and load a NOP.
- EXE_MEM_CE  out  1  EXE_MEM enable.
- MEM_WB_CE  out  1  MEM_WB enable.
- mem_err  out  1  one-cycle pulse on dmem timeout.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush events.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_err=0.
  - While rst_n=0, all CE outputs=1 and IF_ID_flush=ID_EXE_bubble=0, regardless of other inputs.
- States: RUN, MEM_WAIT. Control outputs are combinational from state and inputs (same-cycle action, zero latency). mem_err, counters and state are registered.
- load_use = ID_EXE_RegWrite & (ID_EXE_DatatoReg==LOAD_SEL) & (ID_EXE_written_reg!=0) & ((IF_ID_use_rs1 & rs1==rd) | (IF_ID_use_rs2 & rs2==rd)).
- mem_stall = dmem_req & ~dmem_ready.
- Priority, evaluated each cycle:
  1. Memory freeze: state==MEM_WAIT, or (RUN & mem_stall). All five CE=0, IF_ID_flush=0, ID_EXE_bubble=0. Branch and load-use are ignored, since they remain presented and are handled after the freeze.
  2. Branch: branch_taken=1. All CE=1, IF_ID_flush=1, ID_EXE_bubble=1. flush_cnt += 1. A simultaneous load_use is dropped because its instruction is squashed.
  3. Load-use: PC_CE=0, IF_ID_CE=0, ID_EXE_bubble=1, EXE_MEM_CE=MEM_WB_CE=1. Exactly one bubble per hazard: the next cycle the load has left ID_EXE, so load_use deasserts naturally.
  4. Otherwise all CE=1 and flush/bubble=0.
- Transitions and wait counter:
  - RUN→MEM_WAIT when mem_stall; wait_cnt←1.
  - In MEM_WAIT, if dmem_ready=1, go to RUN. The freeze still applies in that cycle and the pipeline advances on the following edge.
  - Otherwise wait_cnt increments. When wait_cnt==MEM_TIMEOUT-1 and not ready: mem_err=1 for one cycle, go to RUN, wait_cnt←0.
- The freeze spans exactly the cycles in which dmem_ready=0 plus the cycle ready is sampled.
- Counters:
  - stall_cnt += 1 on every cycle with PC_CE=0.
  - flush_cnt += 1 per branch-flush cycle.
  - Both saturate at all-ones, with no wrap-around.
- rst_n asserted mid-MEM_WAIT returns to RUN immediately; a pending mem_err is cancelled.
- rd==x0 never stalls.

Decomposition:
- Shared package pipe_pkg holds LOAD_SEL, the NOP constant 32'h00000013, and the state encoding (RUN=1'b0, MEM_WAIT=1'b1).
- One natural sub-module: sat_counter (CNT_W-bit saturating incrementer with enable), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: ID_EXE rd=5, DatatoReg=01, RegWrite=1; ID rs1=5, use_rs1=1.
  - Response: PC_CE=IF_ID_CE=0, ID_EXE_bubble=1 for exactly 1 cycle; stall_cnt 0→1.
- x0 and non-load cases:
  - Stimulus: same as load-use but rd=0, or DatatoReg=00.
  - Response: no stall; all CE=1; stall_cnt unchanged.
- Branch with simultaneous load-use:
  - Stimulus: branch_taken=1 together with a load-use condition.
  - Response: IF_ID_flush=1, ID_EXE_bubble=1, PC_CE=1; flush_cnt=1; stall_cnt=0.
- Memory wait:
  - Stimulus: dmem_req=1, dmem_ready=0 for 3 cycles, then 1.
  - Response: all CE=0 for 4 cycles, state returns to RUN; stall_cnt=4. A branch_taken held through the wait is serviced the cycle after.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmem_ready held 0.
  - Response: mem_err pulses once on the 4th wait cycle; next cycle state=RUN and CE=0 again (new wait begins).
- Reset and saturation:
  - Stimulus: rst_n driven low mid-MEM_WAIT; also counters at 16'hFFFF with further stalls.
  - Response: reset gives immediate CE=1, counters=0, no mem_err. Counters at 16'hFFFF stay at 16'hFFFF after further stalls.
